// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in, parallel-out register.
package sipo_pkg;

    localparam int SIPO_WIDTH     = 8;
    localparam int SIPO_TAP_WIDTH = 4;

    function automatic int count_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter; registers a one-cycle pulse on each wrap.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [count_w(WIDTH)-1:0] count,
    output logic                      wrap
);

    localparam int CW = count_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wrap_q;
    logic          wrap_d;

    always_comb begin
        count_d = count_q + CW'(1);
        wrap_d  = 1'b0;
        if (count_q == LAST) begin
            count_d = '0;
            wrap_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/sipo_register.sv
// Serial-in, parallel-out shift register, LSB-first, with word framing.
module sipo_register
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter int TAP_WIDTH = SIPO_TAP_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_in,
    output logic [WIDTH-1:0]          parallel_out_full,
    output logic [TAP_WIDTH-1:0]      parallel_out_last_4_bits,
    output logic [count_w(WIDTH)-1:0] bit_count,
    output logic                      word_valid
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Newest bit enters at the MSB so a full LSB-first word lands in order.
    always_comb begin
        sr_d = {serial_in, sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    sipo_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .count (bit_count),
        .wrap  (word_valid)
    );

    assign parallel_out_full        = sr_q;
    assign parallel_out_last_4_bits = sr_q[WIDTH-1 -: TAP_WIDTH];

endmodule

// File: tb/tb_sipo_register.sv
// Directed self-checking bench for sipo_register (WIDTH=8, TAP_WIDTH=4).
module tb_sipo_register;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] full;
    logic [3:0] last4;
    logic [3:0] bit_count;
    logic       word_valid;

    int total;
    int bad;

    sipo_register #(
        .WIDTH(8),
        .TAP_WIDTH(4)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .serial_in                (serial_in),
        .parallel_out_full        (full),
        .parallel_out_last_4_bits (last4),
        .bit_count                (bit_count),
        .word_valid               (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        serial_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic shift_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        serial_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (full !== 8'h00 || last4 !== 4'h0) begin
                bad++;
                $display("FAIL reset_data got=%h/%h exp=00/0", full, last4);
            end
            total++;
            if (bit_count !== 4'd0 || word_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctrl got=%0d/%b exp=0/0",
                         bit_count, word_valid);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [7:0] exp_full [1:8];
        w = 8'b10110101;
        exp_full[1] = 8'b10000000;
        exp_full[2] = 8'b01000000;
        exp_full[3] = 8'b10100000;
        exp_full[4] = 8'b01010000;
        exp_full[5] = 8'b10101000;
        exp_full[6] = 8'b11010100;
        exp_full[7] = 8'b01101010;
        exp_full[8] = 8'hB5;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            shift_bit(w[k-1]);
            total++;
            if (full !== exp_full[k]) begin
                bad++;
                $display("FAIL single_full[%0d] got=%h exp=%h",
                         k, full, exp_full[k]);
            end
            total++;
            if (bit_count !== 4'(k % 8)) begin
                bad++;
                $display("FAIL single_count[%0d] got=%0d exp=%0d",
                         k, bit_count, k % 8);
            end
            total++;
            if (word_valid !== (k == 8)) begin
                bad++;
                $display("FAIL single_valid[%0d] got=%b exp=%b",
                         k, word_valid, (k == 8));
            end
        end
        total++;
        if (last4 !== 4'b1011) begin
            bad++;
            $display("FAIL single_last4 got=%b exp=1011", last4);
        end
        shift_bit(1'b0);
        total++;
        if (word_valid !== 1'b0 || bit_count !== 4'd1) begin
            bad++;
            $display("FAIL single_after got=%b/%0d exp=0/1",
                     word_valid, bit_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        s = 16'h3CB5;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            shift_bit(s[k-1]);
            total++;
            if (word_valid !== (k == 8 || k == 16)) begin
                bad++;
                $display("FAIL b2b_valid[%0d] got=%b exp=%b",
                         k, word_valid, (k == 8 || k == 16));
            end
            if (k == 8) begin
                total++;
                if (full !== 8'hB5) begin
                    bad++;
                    $display("FAIL b2b_word0 got=%h exp=b5", full);
                end
            end
            if (k == 16) begin
                total++;
                if (full !== 8'h3C || last4 !== 4'h3) begin
                    bad++;
                    $display("FAIL b2b_word1 got=%h/%h exp=3c/3",
                             full, last4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 5; k++) shift_bit(1'b1);
        total++;
        if (full !== 8'hF8 || bit_count !== 4'd5) begin
            bad++;
            $display("FAIL pre_reset got=%h/%0d exp=f8/5", full, bit_count);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (full !== 8'h00 || last4 !== 4'h0 ||
            bit_count !== 4'd0 || word_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_clear got=%h/%h/%0d/%b exp=00/0/0/0",
                     full, last4, bit_count, word_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (full !== 8'h00) begin
            bad++;
            $display("FAIL async_hold got=%h exp=00", full);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            shift_bit(1'b1);
            total++;
            if (word_valid !== (k == 8)) begin
                bad++;
                $display("FAIL rst_valid[%0d] got=%b exp=%b",
                         k, word_valid, (k == 8));
            end
        end
        total++;
        if (full !== 8'hFF) begin
            bad++;
            $display("FAIL rst_word got=%h exp=ff", full);
        end
    endtask

    task automatic test_saturate_drain();
        logic [7:0] exp_drain [1:8];
        exp_drain[1] = 8'h7F;
        exp_drain[2] = 8'h3F;
        exp_drain[3] = 8'h1F;
        exp_drain[4] = 8'h0F;
        exp_drain[5] = 8'h07;
        exp_drain[6] = 8'h03;
        exp_drain[7] = 8'h01;
        exp_drain[8] = 8'h00;
        do_reset();
        for (int k = 0; k < 10; k++) shift_bit(1'b1);
        total++;
        if (full !== 8'hFF || last4 !== 4'hF) begin
            bad++;
            $display("FAIL saturate got=%h/%h exp=ff/f", full, last4);
        end
        for (int k = 1; k <= 8; k++) begin
            shift_bit(1'b0);
            total++;
            if (full !== exp_drain[k]) begin
                bad++;
                $display("FAIL drain[%0d] got=%h exp=%h",
                         k, full, exp_drain[k]);
            end
        end
        total++;
        if (bit_count !== 4'd2) begin
            bad++;
            $display("FAIL drain_count got=%0d exp=2", bit_count);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        serial_in = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_async_reset();
        test_saturate_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
